// File: rtl/approx_add_pipe.sv
// approx_add_pipe: pipelined approximate/exact unsigned adder with valid/ready flow control.
// Low APPROX_BITS result bits are A|B in approximate mode; the upper part is a carry-ripple
// add split into STAGES register slices, so a result leaves STAGES cycles after acceptance.
// Optional feature macro: ERROR_STATS_EN adds error counters (stats_clr, err_cnt, err_sum).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (A, B, exact_mode)
//   out_valid / out_ready result handshake (O, WIDTH+1 bits, never wraps)
//   stats_clr, err_cnt, err_sum   (ERROR_STATS_EN only) clear, error count, summed |error|
module approx_add_pipe #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned APPROX_BITS = 6,
    parameter int unsigned STAGES      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             exact_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   O
`ifdef ERROR_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [31:0]      err_cnt,
    output logic [31:0]      err_sum
`endif
);

    localparam int unsigned UW = WIDTH - APPROX_BITS;
    localparam int SW = int'((UW + STAGES - 1) / STAGES);
    localparam logic [WIDTH-1:0] LO_MASK  = WIDTH'((65'd1 << APPROX_BITS) - 65'd1);
    // Single-bit mask of the top approximate bit (zero when APPROX_BITS = 0)
    localparam logic [WIDTH-1:0] TOP_MASK = LO_MASK ^ (LO_MASK >> 1);

    // Whole pipeline moves together; a stalled output freezes every stage
    assign in_ready = out_ready | ~out_valid;

    // Low part, resolved before the first register: OR bits or exact low sum plus its carry
    logic [WIDTH-1:0] lo_sum;
    logic [WIDTH-1:0] res0;
    logic             c0;

    assign lo_sum = (A & LO_MASK) + (B & LO_MASK);
    assign res0   = exact_mode ? (lo_sum & LO_MASK) : ((A | B) & LO_MASK);
    assign c0     = exact_mode ? lo_sum[APPROX_BITS] : (|(A & B & TOP_MASK));

    // One upper-add slice per stage; operands not yet consumed ride along in g_op
    for (genvar s = 0; s < STAGES; s++) begin : g_st
        localparam int LO = s * SW;
        localparam int HI = (s + 1) * SW;

        logic [UW-1:0]    a_in, b_in;
        logic [WIDTH-1:0] r_in, r_d, r_q;
        logic             c_in, c_d, c_q;
        logic             v_in, v_q;
`ifdef ERROR_STATS_EN
        logic [WIDTH:0]   ex_in, ex_q;
`endif

        if (s == 0) begin : g_src
            assign a_in = A[WIDTH-1:APPROX_BITS];
            assign b_in = B[WIDTH-1:APPROX_BITS];
            assign r_in = res0;
            assign c_in = c0;
            assign v_in = in_valid;
`ifdef ERROR_STATS_EN
            assign ex_in = (WIDTH+1)'(A) + (WIDTH+1)'(B);
`endif
        end else begin : g_src
            assign a_in = g_op[s-1].a_q;
            assign b_in = g_op[s-1].b_q;
            assign r_in = g_st[s-1].r_q;
            assign c_in = g_st[s-1].c_q;
            assign v_in = g_st[s-1].v_q;
`ifdef ERROR_STATS_EN
            assign ex_in = g_st[s-1].ex_q;
`endif
        end

        // Ripple the carry through this stage's slice of upper bits [LO, HI)
        always_comb begin
            r_d = r_in;
            c_d = c_in;
            for (int i = 0; i < int'(UW); i++) begin
                if (i >= LO && i < HI) begin
                    r_d[int'(APPROX_BITS) + i] = a_in[i] ^ b_in[i] ^ c_d;
                    c_d = (a_in[i] & b_in[i]) | (c_d & (a_in[i] ^ b_in[i]));
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                r_q <= '0;
                c_q <= 1'b0;
            end else if (in_ready) begin
                v_q <= v_in;
                r_q <= r_d;
                c_q <= c_d;
            end
        end

`ifdef ERROR_STATS_EN
        // Exact reference sum travels with the result for error measurement
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ex_q <= '0;
            end else if (in_ready) begin
                ex_q <= ex_in;
            end
        end
`endif
    end

    // Operand registers between stages (none after the last stage)
    for (genvar s = 0; s < int'(STAGES) - 1; s++) begin : g_op
        logic [UW-1:0] a_q, b_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                a_q <= '0;
                b_q <= '0;
            end else if (in_ready) begin
                a_q <= g_st[s].a_in;
                b_q <= g_st[s].b_in;
            end
        end
    end

    assign out_valid = g_st[STAGES-1].v_q;
    assign O         = {g_st[STAGES-1].c_q, g_st[STAGES-1].r_q};

`ifdef ERROR_STATS_EN
    localparam int unsigned AW = (WIDTH + 2 > 34) ? WIDTH + 2 : 34;
    localparam logic [AW-1:0] SAT = AW'(32'hFFFF_FFFF);

    logic [WIDTH:0] ex_o, diff;
    logic [AW-1:0]  acc;

    assign ex_o = g_st[STAGES-1].ex_q;
    assign diff = (O >= ex_o) ? (O - ex_o) : (ex_o - O);
    assign acc  = AW'(err_sum) + AW'(diff);

    // Saturating error statistics on output transfers; clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
            err_sum <= '0;
        end else if (stats_clr) begin
            err_cnt <= '0;
            err_sum <= '0;
        end else if (out_valid && out_ready && (diff != '0)) begin
            if (err_cnt != 32'hFFFF_FFFF) begin
                err_cnt <= err_cnt + 32'd1;
            end
            err_sum <= (acc > SAT) ? 32'hFFFF_FFFF : acc[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// Testbench for approx_add_pipe: directed spec vectors, randomized streams with stalls,
// mid-flight reset, and an exhaustive exact-equivalence sweep on a small configuration.
// Error-statistics checks are built when ERROR_STATS_EN is defined.
module tb_approx_add_pipe;
    localparam int unsigned W  = 16;
    localparam int unsigned AB = 6;
    localparam int unsigned ST = 2;
    localparam int unsigned OW = W + 1;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          in_valid   = 1'b0;
    logic          in_ready;
    logic [W-1:0]  A          = '0;
    logic [W-1:0]  B          = '0;
    logic          exact_mode = 1'b0;
    logic          out_valid;
    logic          out_ready  = 1'b1;
    logic [W:0]    O;
`ifdef ERROR_STATS_EN
    logic          stats_clr  = 1'b0;
    logic [31:0]   err_cnt, err_sum;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    approx_add_pipe #(.WIDTH(W), .APPROX_BITS(AB), .STAGES(ST)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .A          (A),
        .B          (B),
        .exact_mode (exact_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .O          (O)
`ifdef ERROR_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .err_cnt    (err_cnt),
        .err_sum    (err_sum)
`endif
    );

    // Four small instances (WIDTH=8, APPROX_BITS=0, STAGES=1) share the exhaustive sweep
    logic       sw_iv = 1'b0;
    logic [7:0] sw_a [4];
    logic [7:0] sw_b [4];
    logic       sw_m [4];
    logic [8:0] sw_o [4];
    logic       sw_v [4];
    logic       sw_r [4];
`ifdef ERROR_STATS_EN
    logic [31:0] sw_ec [4];
    logic [31:0] sw_es [4];
`endif

    for (genvar k = 0; k < 4; k++) begin : g_sw
        approx_add_pipe #(.WIDTH(8), .APPROX_BITS(0), .STAGES(1)) u_sw (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (sw_iv),
            .in_ready   (sw_r[k]),
            .A          (sw_a[k]),
            .B          (sw_b[k]),
            .exact_mode (sw_m[k]),
            .out_valid  (sw_v[k]),
            .out_ready  (1'b1),
            .O          (sw_o[k])
`ifdef ERROR_STATS_EN
            ,
            .stats_clr  (1'b0),
            .err_cnt    (sw_ec[k]),
            .err_sum    (sw_es[k])
`endif
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: arithmetic restatement of the approximate/exact sum rules
    function automatic logic [64:0] ref_sum(input logic [63:0] a, input logic [63:0] b,
                                            input logic m, input int ab);
        logic [64:0] lo, hi;
        logic        cin;
        if (m) return {1'b0, a} + {1'b0, b};
        lo  = {1'b0, a | b} & ((65'd1 << ab) - 65'd1);
        cin = (ab > 0) ? (a[ab-1] & b[ab-1]) : 1'b0;
        hi  = ({1'b0, a} >> ab) + ({1'b0, b} >> ab) + 65'(cin);
        return (hi << ab) | lo;
    endfunction

    // One transaction through an idle pipe: latency, value, and drain
    task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                            input logic [W:0] exp, input string tag);
        @(negedge clk);
        A = a; B = b; exact_mode = m; in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k < int'(ST); k++) begin
            check({tag, "_early_valid"}, 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_O"}, 64'(O), 64'(exp));
        @(posedge clk); #1;
        check({tag, "_drain"}, 64'(out_valid), 64'd0);
    endtask

    // Streamed traffic against a FIFO of predicted results; stall window [stall_lo, stall_hi]
    task automatic run_stream(input string tag, input int n, input int stall_lo,
                              input int stall_hi, input bit rnd);
        logic [W:0] exp_q[$];
        logic [W:0] held;
        bit         holding;
        int         sent, cyc;
        holding = 1'b0; held = '0; sent = 0; cyc = 0;
        while ((sent < n || exp_q.size() > 0) && cyc < 400) begin
            @(negedge clk);
            A          = W'($urandom);
            B          = W'($urandom);
            exact_mode = 1'($urandom_range(0, 1));
            in_valid   = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
            out_ready  = !(cyc >= stall_lo && cyc <= stall_hi) && (!rnd || $urandom_range(0, 2) != 0);
            #1;
            if (out_valid) begin
                if (holding) check({tag, "_hold"}, 64'(O), 64'(held));
                if (!out_ready) begin
                    check({tag, "_in_ready_stall"}, 64'(in_ready), 64'd0);
                    held = O; holding = 1'b1;
                end else begin
                    holding = 1'b0;
                    if (exp_q.size() == 0) check({tag, "_spurious"}, 64'(out_valid), 64'd0);
                    else check({tag, "_data"}, 64'(O), 64'(exp_q.pop_front()));
                end
            end else begin
                holding = 1'b0;
                check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(OW'(ref_sum(64'(A), 64'(B), exact_mode, int'(AB))));
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        check({tag, "_sent"}, 64'(sent), 64'(n));
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        for (int k = 0; k < 4; k++) begin
            sw_a[k] = '0; sw_b[k] = '0; sw_m[k] = 1'b0;
        end

        // Reset state
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_O", 64'(O), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_sw_in_ready", 64'(sw_r[0]), 64'd1);
`ifdef ERROR_STATS_EN
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_err_sum", 64'(err_sum), 64'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_valid", 64'(out_valid), 64'd0);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Spec vectors
        send_one(16'h0030, 16'h0030, 1'b0, 17'h00070, "v30_approx");
        send_one(16'h0030, 16'h0030, 1'b1, 17'h00060, "v30_exact");
`ifdef ERROR_STATS_EN
        check("v30_err_cnt", 64'(err_cnt), 64'd1);
        check("v30_err_sum", 64'(err_sum), 64'h10);
        @(negedge clk); stats_clr = 1'b1;
        @(negedge clk); stats_clr = 1'b0;
        check("clr_err_cnt", 64'(err_cnt), 64'd0);
        check("clr_err_sum", 64'(err_sum), 64'd0);
`endif
        send_one(16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFF, "vff_approx");
        send_one(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFE, "vff_exact");
`ifdef ERROR_STATS_EN
        check("vff_err_cnt", 64'(err_cnt), 64'd1);
        check("vff_err_sum", 64'(err_sum), 64'd1);
        // Clear coinciding with an erroneous output transfer
        @(negedge clk);
        A = 16'hFFFF; B = 16'hFFFF; exact_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("clrhit_valid", 64'(out_valid), 64'd1);
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        check("clrhit_err_cnt", 64'(err_cnt), 64'd0);
        check("clrhit_err_sum", 64'(err_sum), 64'd0);
`endif

        // Random single transactions against the model
        for (int t = 0; t < 6; t++) begin
            ra = W'($urandom); rb = W'($urandom);
            send_one(ra, rb, 1'(t % 2), OW'(ref_sum(64'(ra), 64'(rb), 1'(t % 2), int'(AB))), "rand_one");
        end

        // Back-to-back stream with a stall, then random traffic
        run_stream("stream8", 8, 3, 5, 1'b0);
        run_stream("stream_rand", 60, -1, -1, 1'b1);

        // Reset with two transactions in flight
        @(negedge clk);
        A = 16'd1; B = 16'd2; exact_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        A = 16'd3; B = 16'd4;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("inflight_valid", 64'(out_valid), 64'd1);
        check("inflight_O", 64'(O), 64'd3);
        rst = 1'b1;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_O", 64'(O), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("midrst_stale", 64'(out_valid), 64'd0);
        end
        send_one(16'h1234, 16'h0F0F, 1'b0,
                 OW'(ref_sum(64'h1234, 64'h0F0F, 1'b0, int'(AB))), "post_midrst");

        // Exhaustive sweep: both modes must give A+B with no approximate bits
        sw_iv = 1'b1;
        for (int a = 0; a < 128; a++) begin
            for (int b = 0; b < 256; b++) begin
                @(negedge clk);
                for (int k = 0; k < 4; k++) begin
                    sw_a[k] = 8'(a + 128 * (k / 2));
                    sw_b[k] = 8'(b);
                    sw_m[k] = 1'(k % 2);
                end
                @(posedge clk); #1;
                for (int k = 0; k < 4; k++) begin
                    check("sweep_valid", 64'(sw_v[k]), 64'd1);
                    check("sweep_O", 64'(sw_o[k]), 64'(sw_a[k]) + 64'(sw_b[k]));
                end
            end
        end
        sw_iv = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/approx_add_pipe.md
APPROX_ADD_PIPE -- requirements
Module: approx_add_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (legal range 4..64).
REQ-002 SHALL have parameter APPROX_BITS, default 6, number of low result bits computed approximately (legal range 0..WIDTH-1).
REQ-003 SHALL have parameter STAGES, default 2, number of register stages from input to output (legal range 1..4).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operand pair A/B/exact_mode is valid this cycle.
REQ-007 in_ready  output  1  block accepts the operand pair this cycle.
REQ-008 A  input  WIDTH  first unsigned operand.
REQ-009 B  input  WIDTH  second unsigned operand.
REQ-010 exact_mode  input  1  1 = exact sum for this transaction; 0 = approximate sum.
REQ-011 out_valid  output  1  O holds a result.
REQ-012 out_ready  input  1  consumer accepts O this cycle.
REQ-013 O  output  WIDTH+1  unsigned sum.
REQ-014 With ERROR_STATS_EN defined: stats_clr input 1, err_cnt output 32, err_sum output 32 (see REQ-031).

Function
REQ-015 Approximate mode: O[i] = A[i] | B[i] for i < APPROX_BITS.
REQ-016 Approximate mode: O[WIDTH:APPROX_BITS] = A[WIDTH-1:APPROX_BITS] + B[WIDTH-1:APPROX_BITS] + cin, with cin = A[APPROX_BITS-1] & B[APPROX_BITS-1], or cin = 0 when APPROX_BITS = 0.
REQ-017 Exact mode: O = A + B, zero-extended to WIDTH+1 bits, with the carry out in O[WIDTH].
REQ-018 The upper add SHALL be split into STAGES contiguous slices of ceil((WIDTH-APPROX_BITS)/STAGES) bits, with the last slice taking the remainder; the inter-slice carry and the unprocessed operand bits SHALL be registered between stages.
REQ-019 exact_mode SHALL be captured with its operands and travel with them; a mode change between transactions SHALL NOT affect transactions already in flight.
REQ-020 Handshake: a transfer occurs when valid and ready are both high on a rising edge; in_ready = out_ready | ~out_valid.
REQ-021 The pipeline SHALL advance as a whole only when in_ready is high; otherwise every stage holds, including bubbles.
REQ-022 Latency: with out_ready held high, the result SHALL appear at O with out_valid high exactly STAGES cycles after acceptance; throughput is one result per cycle.
REQ-023 While out_valid is high and out_ready is low, O and out_valid SHALL be held stable.
REQ-024 Per-stage valid bits SHALL propagate bubbles; out_valid is the last stage's valid bit.
REQ-025 The full width SHALL always be used; the WIDTH+1 result SHALL NOT wrap.

Reset
REQ-026 While rst is high: all stage valid bits = 0, out_valid = 0, O = 0.
REQ-027 rst asserted mid-operation SHALL discard all in-flight transactions with no partial output.
REQ-028 in_ready SHALL be 1 during and after reset, because out_valid = 0.
REQ-029 With ERROR_STATS_EN defined: err_cnt = 0 and err_sum = 0 on reset.

Configuration
REQ-030 Macro ERROR_STATS_EN SHALL select whether error statistics are built.
REQ-031 With ERROR_STATS_EN defined:
- Each output transfer where O differs from the exact sum increments err_cnt by 1 and adds |O - exact| to err_sum.
- Both counters saturate at 0xFFFFFFFF.
- The exact sum SHALL be carried alongside the result through the pipeline.
- stats_clr = 1 zeroes both counters synchronously; when it coincides with an update, the clear wins.
REQ-032 Without ERROR_STATS_EN, the stats ports and their logic SHALL be absent, and datapath behaviour SHALL be identical.

Verification
REQ-033 Defaults; A=0x0030, B=0x0030, exact_mode=0, out_ready=1 -> O=0x00070 two cycles later; with exact_mode=1 -> O=0x00060.
REQ-034 A=0xFFFF, B=0xFFFF: exact_mode=0 -> O=0x1FFFF; exact_mode=1 -> O=0x1FFFE; with ERROR_STATS_EN, after both -> err_cnt=1, err_sum=1.
REQ-035 Back-to-back stream of 8 transactions with out_ready low for cycles 3-5 -> all 8 results in order, O stable while stalled, in_ready low while out_valid=1 and out_ready=0.
REQ-036 rst pulsed with 2 transactions in flight -> out_valid=0 and O=0 immediately; no stale result after release.
REQ-037 Parameter sweep WIDTH=8, APPROX_BITS=0, STAGES=1 over exhaustive A/B in both modes -> O always equals A+B.
REQ-038 ERROR_STATS_EN: stats_clr asserted in the same cycle as an erroneous transfer -> err_cnt=0, err_sum=0 next cycle.
